hazard_scoreboard: RTL

- Parametrised successor to the pipeline's combinational hazard detector.
- Keeps a per-register pending-write scoreboard with countdown timers, and drives the stall/bubble controls for the IF/ID and ID/EX boundaries.
- Supports per-class result latencies (ALU vs load), an optional forwarding mode and squash/flush.
- Sits beside the decode stage and feeds the PC, the IF/ID register and the ID/EX control mux.

---
 rtl/pipe_pkg.sv | 26 ++
 rtl/sb_timer.sv | 32 +++
 rtl/hazard_scoreboard.sv | 88 ++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_pkg                                                             |
// | Shared pipeline constants, register-index type, latency helper.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package pipe_pkg;

    localparam int REG_IDX_W    = 4;
    localparam int DEF_ALU_LAT  = 2;
    localparam int DEF_LOAD_LAT = 3;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    // With forwarding the ALU result is bypassed, so only the load's extra
    // cycles beyond the ALU path remain visible to the reader.
    function automatic int eff_lat(input logic is_load, input logic fwd_en,
                                   input int alu_lat, input int load_lat);
        if (fwd_en)
            return is_load ? (load_lat - alu_lat) : 0;
        else
            return is_load ? load_lat : alu_lat;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sb_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sb_timer                                                             |
// | Single-register pending-write countdown with a load port.            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module sb_timer #(
    parameter int W = 2
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         busy
);

    logic [W-1:0] r_count;

    // A fresh load overrides the decrement so a later writer re-arms the timer.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            r_count <= '0;
        else if (load)
            r_count <= load_val;
        else if (r_count != '0)
            r_count <= r_count - W'(1);
    end

    assign busy = (r_count != '0);

endmodule
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hazard_scoreboard                                                    |
// | Per-register pending-write scoreboard driving IF/ID and ID/EX stalls.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module hazard_scoreboard
    import pipe_pkg::*;
#(
    parameter int REG_ADDR_W = REG_IDX_W,
    parameter int NUM_REGS   = 16,
    parameter int ALU_LAT    = DEF_ALU_LAT,
    parameter int LOAD_LAT   = DEF_LOAD_LAT,
    parameter int FWD_EN     = 0,
    parameter int R0_ZERO    = 1,
    parameter int CNT_W      = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_op1,
    input  logic [REG_ADDR_W-1:0] id_op2,
    input  logic                  id_use1,
    input  logic                  id_use2,
    input  logic [REG_ADDR_W-1:0] id_dest,
    input  logic                  id_writes,
    input  logic                  id_is_load,
    input  logic                  flush,
    output logic                  has_hazard,
    output logic                  pc_write,
    output logic                  if_id_hold,
    output logic                  id_ex_bubble,
    output logic [CNT_W-1:0]      stall_count
);

    localparam int MAX_LAT = (ALU_LAT > LOAD_LAT) ? ALU_LAT : LOAD_LAT;
    localparam int TW      = (MAX_LAT > 0) ? $clog2(MAX_LAT + 1) : 1;
    localparam int SLOTS   = 1 << REG_ADDR_W;

    logic [SLOTS-1:0] w_busy;
    logic [TW-1:0]    w_lat;
    logic             w_hazard;
    logic             w_dest_tracked;
    logic             w_issue;
    logic [CNT_W-1:0] r_stall_cnt;

    assign w_lat = TW'(eff_lat(id_is_load, FWD_EN != 0, ALU_LAT, LOAD_LAT));

    assign w_dest_tracked = (int'(id_dest) < NUM_REGS) &&
                            !((R0_ZERO != 0) && (id_dest == '0));

    // Reset gating keeps the controls idle even if a flush arrives in reset.
    assign w_hazard = ~reset & id_valid & ~flush &
                      ((id_use1 & w_busy[id_op1]) | (id_use2 & w_busy[id_op2]));

    assign w_issue = id_valid & ~w_hazard & ~flush & id_writes & w_dest_tracked;

    for (genvar r = 0; r < SLOTS; r++) begin : g_slot
        if ((r >= NUM_REGS) || ((R0_ZERO != 0) && (r == 0))) begin : g_untracked
            assign w_busy[r] = 1'b0;
        end else begin : g_tracked
            sb_timer #(
                .W        (TW)
            ) u_timer (
                .clock    (clock),
                .reset    (reset),
                .load     (w_issue && (id_dest == REG_ADDR_W'(r))),
                .load_val (w_lat),
                .busy     (w_busy[r])
            );
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            r_stall_cnt <= '0;
        else if (w_hazard && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end

    assign has_hazard   = w_hazard;
    assign pc_write     = ~w_hazard;
    assign if_id_hold   = w_hazard;
    assign id_ex_bubble = ~reset & (w_hazard | flush);
    assign stall_count  = r_stall_cnt;

endmodule
`default_nettype wire
